// File: rtl/isram_banked_arb_pkg.sv
// rtl/isram_banked_arb_pkg.sv - shared types, port codes and bank geometry helpers for the banked ISRAM
package isram_banked_arb_pkg;

    localparam int DEF_DW    = 64;
    localparam int DEF_BW    = 8;
    localparam int DEF_NBANK = 2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic vld;
        logic port;
        logic wr;
    } inflight_t;

    function automatic int bank_dw(input int dw, input int nbank);
        return dw / nbank;
    endfunction

    function automatic int bank_bw(input int bw, input int nbank);
        return bw / nbank;
    endfunction

    localparam int BANK_DW = bank_dw(DEF_DW, DEF_NBANK);
    localparam int BANK_BW = bank_bw(DEF_BW, DEF_NBANK);

endpackage

// File: rtl/isram_col_bank.sv
// rtl/isram_col_bank.sv - single-port synchronous SRAM column with byte writes and registered read address
module isram_col_bank
    import isram_banked_arb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int W   = BANK_DW,
    parameter int BEW = BANK_BW
) (
    input  logic           clk,
    input  logic           csn,
    input  logic           wen,
    input  logic [BEW-1:0] ben,
    input  logic [AW-1:0]  addr,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!csn) begin
            addr_q <= addr;
            if (!wen) begin
                for (int i = 0; i < BEW; i++) begin
                    if (ben[i]) begin
                        mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end
        end
    end

    assign dout = mem[addr_q];

endmodule

// File: rtl/isram_banked_arb.sv
// rtl/isram_banked_arb.sv - banked instruction SRAM with round-robin fetch/loader front end
module isram_banked_arb
    import isram_banked_arb_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 64,
    parameter int BW    = 8,
    parameter int NBANK = 2,
    parameter int OREG  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic [AW-1:0] a_req_addr,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_wen,
    input  logic [BW-1:0] b_req_ben,
    input  logic [AW-1:0] b_req_addr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_rdata
);

    localparam int CW = bank_dw(DW, NBANK);
    localparam int CB = bank_bw(BW, NBANK);
    localparam int D  = 1 + OREG;

    logic             rr;
    logic             gnt_a;
    logic             gnt_b;
    logic             acc;
    logic             acc_wr;
    logic [AW-1:0]    acc_addr;
    logic [NBANK-1:0] bank_csn;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    r_data;
    logic [DW-1:0]    a_hold;
    logic             a_sel;
    logic             b_sel;
    inflight_t        pipe [D];
    inflight_t        rsp;

    always_comb begin
        gnt_a = !rst && a_req_valid && (!b_req_valid || rr == PORT_A);
        gnt_b = !rst && b_req_valid && (!a_req_valid || rr == PORT_B);
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;
    assign acc         = gnt_a || gnt_b;
    assign acc_wr      = gnt_b && b_req_wen;
    assign acc_addr    = gnt_b ? b_req_addr : a_req_addr;

    // The winner of a contested cycle hands priority to the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= PORT_A;
        end else if (a_req_valid && b_req_valid) begin
            rr <= ~rr;
        end
    end

    for (genvar k = 0; k < NBANK; k++) begin : g_bank
        logic [CB-1:0] ben_k;
        assign ben_k       = b_req_ben[k*CB +: CB];
        assign bank_csn[k] = !(gnt_a || (gnt_b && (!b_req_wen || (|ben_k))));

        isram_col_bank #(
            .AW  (AW),
            .W   (CW),
            .BEW (CB)
        ) u_bank (
            .clk  (clk),
            .csn  (bank_csn[k]),
            .wen  (!acc_wr),
            .ben  (ben_k),
            .addr (acc_addr),
            .din  (b_req_wdata[k*CW +: CW]),
            .dout (rd_data[k*CW +: CW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: acc, port: (gnt_b ? PORT_B : PORT_A), wr: acc_wr};
            for (int i = 1; i < D; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rsp = pipe[D-1];

    // Capturing the column output when the read lands freezes it against later writes.
    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (pipe[0].vld && !pipe[0].wr) begin
                rd_q <= rd_data;
            end
        end
        assign r_data = rd_q;
    end else begin : g_noreg
        assign r_data = rd_data;
    end

    assign a_sel = !rst && rsp.vld && rsp.port == PORT_A;
    assign b_sel = !rst && rsp.vld && rsp.port == PORT_B;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_hold <= '0;
        end else if (a_sel) begin
            a_hold <= r_data;
        end
    end

    assign a_rsp_valid = a_sel;
    assign a_rsp_rdata = rst ? '0 : (a_sel ? r_data : a_hold);
    assign b_rsp_valid = b_sel;
    assign b_rsp_rdata = (b_sel && !rsp.wr) ? r_data : '0;

endmodule

// File: tb/tb_isram_banked_arb.sv
// tb/tb_isram_banked_arb.sv - directed self-checking bench driving OREG=0 and OREG=1 instances in lockstep
module tb_isram_banked_arb;

    logic        clk;
    logic        rst;
    logic        a_req_valid;
    logic [15:0] a_req_addr;
    logic        b_req_valid;
    logic        b_req_wen;
    logic [7:0]  b_req_ben;
    logic [15:0] b_req_addr;
    logic [63:0] b_req_wdata;

    logic        a0_rdy, a0_v, b0_rdy, b0_v;
    logic [63:0] a0_d, b0_d;
    logic        a1_rdy, a1_v, b1_rdy, b1_v;
    logic [63:0] a1_d, b1_d;

    int n_tests = 0;
    int n_fail  = 0;

    isram_banked_arb #(.OREG(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a0_rdy), .a_req_addr(a_req_addr),
        .a_rsp_valid(a0_v), .a_rsp_rdata(a0_d),
        .b_req_valid(b_req_valid), .b_req_ready(b0_rdy), .b_req_wen(b_req_wen),
        .b_req_ben(b_req_ben), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b0_v), .b_rsp_rdata(b0_d)
    );

    isram_banked_arb #(.OREG(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a1_rdy), .a_req_addr(a_req_addr),
        .a_rsp_valid(a1_v), .a_rsp_rdata(a1_d),
        .b_req_valid(b_req_valid), .b_req_ready(b1_rdy), .b_req_wen(b_req_wen),
        .b_req_ben(b_req_ben), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b1_v), .b_rsp_rdata(b1_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [15:0] aa;
        logic        bv;
        logic        bw;
        logic [7:0]  be;
        logic [15:0] ba;
        logic [63:0] bd;
        logic        ar;
        logic        br;
        logic [1:0]  csn;
        logic        eav;
        logic [63:0] ead;
        logic        ebv;
        logic [63:0] ebd;
    } vec_t;

    localparam logic [63:0] C1 = 64'h1122334455667788;
    localparam logic [63:0] F1 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] P  = 64'hFFFFFFFF00000000;
    localparam logic [63:0] Q  = 64'hAABBCCDD00000000;
    localparam logic [63:0] R  = 64'h55BBCCDD00000066;

    vec_t vt [14];

    function automatic vec_t mk(logic av, logic [15:0] aa, logic bv, logic bw, logic [7:0] be,
                                logic [15:0] ba, logic [63:0] bd, logic ar, logic br, logic [1:0] csn,
                                logic eav, logic [63:0] ead, logic ebv, logic [63:0] ebd);
        vec_t v;
        v.av = av; v.aa = aa; v.bv = bv; v.bw = bw; v.be = be; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.csn = csn;
        v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
        return v;
    endfunction

    function automatic logic [63:0] pat(input int i);
        logic [7:0] lo;
        logic [7:0] x3;
        lo = 8'(i);
        x3 = 8'(i * 3);
        return {8'hA5, lo, 16'h0F0F, 8'h5A, x3, 16'hC3C3};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input logic eav, input logic [63:0] ead,
                           input logic ebv, input logic [63:0] ebd);
        if (d == 0) begin
            chk({tag, " dut0 a_rsp_valid"}, 64'(a0_v), 64'(eav));
            chk({tag, " dut0 a_rsp_rdata"}, a0_d, ead);
            chk({tag, " dut0 b_rsp_valid"}, 64'(b0_v), 64'(ebv));
            chk({tag, " dut0 b_rsp_rdata"}, b0_d, ebd);
        end else begin
            chk({tag, " dut1 a_rsp_valid"}, 64'(a1_v), 64'(eav));
            chk({tag, " dut1 a_rsp_rdata"}, a1_d, ead);
            chk({tag, " dut1 b_rsp_valid"}, 64'(b1_v), 64'(ebv));
            chk({tag, " dut1 b_rsp_rdata"}, b1_d, ebd);
        end
    endtask

    task automatic drive(input logic av, input logic [15:0] aa, input logic bv, input logic bw,
                         input logic [7:0] be, input logic [15:0] ba, input logic [63:0] bd);
        a_req_valid = av; a_req_addr = aa;
        b_req_valid = bv; b_req_wen = bw; b_req_ben = be; b_req_addr = ba; b_req_wdata = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 16'h0, 1'b1, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        tick();
        chk("reset a_req_ready dut0", 64'(a0_rdy), 64'd0);
        chk("reset b_req_ready dut0", 64'(b0_rdy), 64'd0);
        chk("reset a_req_ready dut1", 64'(a1_rdy), 64'd0);
        chk("reset b_req_ready dut1", 64'(b1_rdy), 64'd0);
        chk_out("reset", 0, 1'b0, 64'h0, 1'b0, 64'h0);
        chk_out("reset", 1, 1'b0, 64'h0, 1'b0, 64'h0);
        rst = 1'b0;

        vt[0]  = mk(0, 16'h00, 1, 1, 8'hFF, 16'h10, C1, 0, 1, 2'b00, 0, 64'h0, 1, 64'h0);
        vt[1]  = mk(1, 16'h10, 0, 0, 8'h00, 16'h00, 64'h0, 1, 0, 2'b00, 1, C1, 0, 64'h0);
        vt[2]  = mk(0, 16'h00, 1, 1, 8'hFF, 16'h20, F1, 0, 1, 2'b00, 0, C1, 1, 64'h0);
        vt[3]  = mk(0, 16'h00, 1, 1, 8'h0F, 16'h20, 64'h0, 0, 1, 2'b10, 0, C1, 1, 64'h0);
        vt[4]  = mk(0, 16'h00, 1, 0, 8'h00, 16'h20, 64'h0, 0, 1, 2'b00, 0, C1, 1, P);
        vt[5]  = mk(1, 16'h20, 0, 0, 8'h00, 16'h00, 64'h0, 1, 0, 2'b00, 1, P, 0, 64'h0);
        vt[6]  = mk(0, 16'h00, 1, 1, 8'h00, 16'h20, 64'h123456789ABCDEF0, 0, 1, 2'b11, 0, P, 1, 64'h0);
        vt[7]  = mk(1, 16'h20, 0, 0, 8'h00, 16'h00, 64'h0, 1, 0, 2'b00, 1, P, 0, 64'h0);
        vt[8]  = mk(0, 16'h00, 1, 1, 8'hFF, 16'h30, 64'h0, 0, 1, 2'b00, 0, P, 1, 64'h0);
        vt[9]  = mk(0, 16'h00, 1, 1, 8'hF0, 16'h30, 64'hAABBCCDDEEFF0011, 0, 1, 2'b01, 0, P, 1, 64'h0);
        vt[10] = mk(0, 16'h00, 1, 0, 8'h00, 16'h30, 64'h0, 0, 1, 2'b00, 0, P, 1, Q);
        vt[11] = mk(0, 16'h00, 1, 1, 8'h81, 16'h30, 64'h5500000000000066, 0, 1, 2'b00, 0, P, 1, 64'h0);
        vt[12] = mk(1, 16'h30, 0, 0, 8'h00, 16'h00, 64'h0, 1, 0, 2'b00, 1, R, 0, 64'h0);
        vt[13] = mk(0, 16'h00, 0, 0, 8'h00, 16'h00, 64'h0, 0, 0, 2'b11, 0, R, 0, 64'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].av, vt[i].aa, vt[i].bv, vt[i].bw, vt[i].be, vt[i].ba, vt[i].bd);
            #1;
            chk($sformatf("vec%0d a_req_ready", i), 64'(a0_rdy), 64'(vt[i].ar));
            chk($sformatf("vec%0d b_req_ready", i), 64'(b0_rdy), 64'(vt[i].br));
            chk($sformatf("vec%0d dut1 b_req_ready", i), 64'(b1_rdy), 64'(vt[i].br));
            chk($sformatf("vec%0d bank_csn dut0", i), 64'(dut0.bank_csn), 64'(vt[i].csn));
            chk($sformatf("vec%0d bank_csn dut1", i), 64'(dut1.bank_csn), 64'(vt[i].csn));
            tick();
            chk_out($sformatf("vec%0d", i), 0, vt[i].eav, vt[i].ead, vt[i].ebv, vt[i].ebd);
            if (i > 0) begin
                chk_out($sformatf("vec%0d lag", i - 1), 1, vt[i-1].eav, vt[i-1].ead, vt[i-1].ebv, vt[i-1].ebd);
            end else begin
                chk_out("vec0 lag idle", 1, 1'b0, 64'h0, 1'b0, 64'h0);
            end
        end

        // Contention from a fresh reset: grants must alternate A, B, A, B.
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'h10, 1'b1, 1'b0, 8'h00, 16'h20, 64'h0);
            #1;
            chk($sformatf("contend%0d a_req_ready", k), 64'(a0_rdy), 64'((k % 2) == 0));
            chk($sformatf("contend%0d b_req_ready", k), 64'(b0_rdy), 64'((k % 2) == 1));
            tick();
            if ((k % 2) == 0) chk_out($sformatf("contend%0d", k), 0, 1'b1, C1, 1'b0, 64'h0);
            else              chk_out($sformatf("contend%0d", k), 0, 1'b0, C1, 1'b1, P);
            if (k == 0)      chk_out("contend0 lag", 1, 1'b0, 64'h0, 1'b0, 64'h0);
            else if (k == 2) chk_out("contend1 lag", 1, 1'b0, C1, 1'b1, P);
            else             chk_out($sformatf("contend%0d lag", k - 1), 1, 1'b1, C1, 1'b0, 64'h0);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        chk_out("contend3 lag", 1, 1'b0, C1, 1'b1, P);

        // Back-to-back streaming of addresses 0..7.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b1, 8'hFF, 16'(i), pat(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 16'(i), 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
            #1;
            if (i < 8) chk($sformatf("stream%0d a_req_ready dut1", i), 64'(a1_rdy), 64'd1);
            tick();
            if (i < 8) begin
                chk($sformatf("stream%0d dut0 a_rsp_valid", i), 64'(a0_v), 64'd1);
                chk($sformatf("stream%0d dut0 a_rsp_rdata", i), a0_d, pat(i));
            end
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream%0d dut1 a_rsp_valid", i - 1), 64'(a1_v), 64'd1);
                chk($sformatf("stream%0d dut1 a_rsp_rdata", i - 1), a1_d, pat(i - 1));
            end else begin
                chk($sformatf("stream edge%0d dut1 a_rsp_valid", i), 64'(a1_v), 64'd0);
            end
        end

        // Reset one cycle after acceptance drops the in-flight read.
        drive(1'b1, 16'h10, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst a_req_ready dut1", 64'(a1_rdy), 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        #1;
        chk_out("midrst", 1, 1'b0, 64'h0, 1'b0, 64'h0);
        chk_out("midrst", 0, 1'b0, 64'h0, 1'b0, 64'h0);
        drive(1'b1, 16'h10, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0, 64'h0);
        tick();
        chk_out("postrst read", 1, 1'b1, C1, 1'b0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
